// File: rtl/acc_window_ctrl.sv
// acc_window_ctrl: counts a window of len cycles and accumulates din.
// Define ACC_WINDOW_SAT_EN for saturating accumulation; default wraps.
module acc_window_ctrl #(
  parameter int WIDTH = 8,
  parameter int IN_W  = 4,
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [IN_W-1:0]  din,
  input  logic             din_valid,
  output logic             busy,
  output logic [WIDTH-1:0] res,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_acc;
  logic             r_ovf;

  logic [WIDTH:0]   w_din_ext;
  logic [WIDTH:0]   w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             w_last;

  assign w_din_ext = {{(WIDTH + 1 - IN_W){1'b0}}, din};
  assign w_sum     = {1'b0, r_acc} + w_din_ext;
  assign w_carry   = w_sum[WIDTH];
  assign w_last    = (r_cnt == LEN_W'(1));

`ifdef ACC_WINDOW_SAT_EN
  assign w_acc_nxt = w_carry ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
  assign w_acc_nxt = w_sum[WIDTH-1:0];
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state: abort beats the final window edge
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (len == '0) ? S_HOLD : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // window counter, accumulator and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt <= len;
            r_acc <= '0;
            r_ovf <= 1'b0;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
          end else begin
            r_cnt <= r_cnt - LEN_W'(1);
            if (din_valid) begin
              r_acc <= w_acc_nxt;
              if (w_carry) begin
                r_ovf <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_cnt <= r_cnt;
        end
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign res_valid = (r_state == S_HOLD);
  assign res       = r_acc;
  assign res_ovf   = r_ovf;

endmodule

// File: tb/tb_acc_window_ctrl.sv
// tb_acc_window_ctrl: directed vectors for acc_window_ctrl.
// Expected values are hand-computed for WIDTH=8, IN_W=4.
module tb_acc_window_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] len;
  logic       abort;
  logic [3:0] din;
  logic       din_valid;
  logic       busy;
  logic [7:0] res;
  logic       res_ovf;
  logic       res_valid;
  logic       res_ready;

  int n_vec;
  int n_err;

  acc_window_ctrl #(
    .WIDTH(8),
    .IN_W (4),
    .LEN_W(10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .abort    (abort),
    .din      (din),
    .din_valid(din_valid),
    .busy     (busy),
    .res      (res),
    .res_ovf  (res_ovf),
    .res_valid(res_valid),
    .res_ready(res_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int ovf_exp;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    len = '0;
    abort = 1'b0;
    din = '0;
    din_valid = 1'b0;
    res_ready = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_res", res, 0);
    chk("rst_ovf", res_ovf, 0);
    chk("rst_valid", res_valid, 0);
    rst = 1'b0;
    step();

    // basic window
    start = 1'b1; len = 10'd5; din = 4'd3; din_valid = 1'b1;
    step();
    start = 1'b0;
    chk("basic_busy", busy, 1);
    for (int i = 0; i < 4; i++) step();
    chk("basic_early", res_valid, 0);
    step();
    chk("basic_valid", res_valid, 1);
    chk("basic_res", res, 15);
    chk("basic_ovf", res_ovf, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("basic_idle", busy, 0);
    chk("basic_keep", res, 15);

    // gaps and back-pressure
    start = 1'b1; len = 10'd4; din = 4'd2;
    step();
    start = 1'b0;
    din_valid = 1'b1; step();
    din_valid = 1'b0; step();
    din_valid = 1'b1; step();
    din_valid = 1'b0; step();
    chk("gap_valid", res_valid, 1);
    chk("gap_res", res, 4);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gap_hold_v", res_valid, 1);
      chk("gap_hold_r", res, 4);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("gap_idle", busy, 0);

    // overflow
    start = 1'b1; len = 10'd20; din = 4'd15; din_valid = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("ovf_valid", res_valid, 1);
`ifdef ACC_WINDOW_SAT_EN
    ovf_exp = 255;
`else
    ovf_exp = 44;
`endif
    chk("ovf_res", res, ovf_exp);
    chk("ovf_flag", res_ovf, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("ovf_keep", res_ovf, 1);

    // start ignored in RUN and on handoff edge
    start = 1'b1; len = 10'd3; din = 4'd1; din_valid = 1'b1;
    step();
    len = 10'd9;
    step();
    step();
    chk("ign_run", res_valid, 0);
    step();
    chk("ign_valid", res_valid, 1);
    chk("ign_res", res, 3);
    chk("ign_ovfclr", res_ovf, 0);
    step();
    chk("ign_hold", res_valid, 1);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    start = 1'b0;
    chk("ign_hand", busy, 0);
    step();
    chk("ign_hand2", busy, 0);

    // zero length
    start = 1'b1; len = 10'd0; din = 4'd7;
    step();
    start = 1'b0;
    chk("zero_valid", res_valid, 1);
    chk("zero_res", res, 0);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // abort on 3rd edge
    start = 1'b1; len = 10'd6; din = 4'd1; din_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab3_busy", busy, 0);
    chk("ab3_res", res, 0);
    chk("ab3_valid", res_valid, 0);

    // abort on final edge
    start = 1'b1; len = 10'd2; din = 4'd4;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abf_busy", busy, 0);
    chk("abf_valid", res_valid, 0);
    chk("abf_res", res, 0);

    // abort ignored in HOLD
    start = 1'b1; len = 10'd1; din = 4'd6;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abh_valid", res_valid, 1);
    chk("abh_res", res, 6);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // async reset mid-run
    start = 1'b1; len = 10'd5; din = 4'd3;
    step();
    start = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_res", res, 0);
    chk("rr_valid", res_valid, 0);
    chk("rr_ovf", res_ovf, 0);
    #3;
    rst = 1'b0;
    step();
    start = 1'b1; len = 10'd1; din = 4'd5;
    step();
    start = 1'b0;
    step();
    chk("rr_again", res, 5);
    chk("rr_again_v", res_valid, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/acc_window_ctrl.md
ACC_WINDOW_CTRL -- requirements
Module: acc_window_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, accumulator/result width in bits.
REQ-002 SHALL have parameter IN_W, default 4, per-cycle increment width in bits (IN_W <= WIDTH).
REQ-003 SHALL have parameter LEN_W, default 10, window-length field width in bits.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begin a window; sampled only in IDLE.
REQ-007 SHALL have port len  input  LEN_W  window length in cycles, captured with start.
REQ-008 SHALL have port abort  input  1  cancel the running window.
REQ-009 SHALL have port din  input  IN_W  unsigned increment.
REQ-010 SHALL have port din_valid  input  1  din is accumulated only when high.
REQ-011 SHALL have port busy  output  1  high in RUN or HOLD.
REQ-012 SHALL have port res  output  WIDTH  accumulated window result.
REQ-013 SHALL have port res_ovf  output  1  sticky overflow flag for the window.
REQ-014 SHALL have port res_valid  output  1  result available.
REQ-015 SHALL have port res_ready  input  1  consumer accepts result.

Function
REQ-016 SHALL implement states IDLE, RUN, HOLD; busy = (state != IDLE); res_valid = (state == HOLD).
REQ-017 In IDLE, start=1 at an edge SHALL capture len into a down-counter, clear accumulator and res_ovf; next state RUN if len != 0, HOLD if len == 0 (res = 0, res_ovf = 0).
REQ-018 In RUN, each edge SHALL add zero-extended din to the accumulator when din_valid=1, hold it otherwise, and decrement the counter.
REQ-019 Window SHALL be exactly len edges following the start edge; on the len-th edge the last din is included and state goes to HOLD, so res_valid rises len cycles after start is sampled.
REQ-020 res SHALL present the accumulator value continuously; it SHALL be stable throughout HOLD.
REQ-021 In HOLD, res_valid & res_ready at an edge SHALL return to IDLE; res and res_ovf hold their values until the next accepted start.
REQ-022 start SHALL be ignored in RUN and HOLD, including on the HOLD->IDLE handoff edge.
REQ-023 abort=1 in RUN SHALL go to IDLE, clear accumulator and res_ovf, produce no result; abort SHALL take priority over the final window edge; abort in IDLE or HOLD SHALL be ignored.
REQ-024 res_ovf SHALL be set on any window edge where accumulator + din exceeds 2^WIDTH-1, and remain set until cleared by start, abort or reset.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter 0, res 0, res_ovf 0, res_valid 0, busy 0, regardless of clock or current state.
REQ-026 Reset asserted mid-window SHALL discard the window; first accepted start after deassertion SHALL behave as from power-up.

Configuration
REQ-027 Macro ACC_WINDOW_SAT_EN defined SHALL make accumulation saturating: on overflow accumulator clamps to 2^WIDTH-1 and stays there for the window.
REQ-028 ACC_WINDOW_SAT_EN undefined SHALL make accumulation wrap modulo 2^WIDTH; res_ovf behaviour per REQ-024 is identical in both builds.

Verification
REQ-029 Basic: len=5, din=3, din_valid=1 all cycles -> res_valid rises 5 cycles after start, res=15, res_ovf=0.
REQ-030 Gaps: len=4, din=2, din_valid=1,0,1,0 -> res=4; res_ready held low 10 cycles -> res_valid and res stay 4; then res_ready=1 -> IDLE next edge.
REQ-031 Overflow (WIDTH=8, IN_W=4): len=20, din=15 -> SAT_EN: res=255, res_ovf=1; no SAT_EN: res=300 mod 256=44, res_ovf=1.
REQ-032 Zero/ignore: len=0 start -> HOLD next edge with res=0; start pulsed during RUN and on HOLD->IDLE edge -> no new window.
REQ-033 Abort and reset: abort on the 3rd edge of len=6 window -> IDLE, res=0, no res_valid; abort coincident with final edge -> no result; rst mid-RUN -> all outputs 0 immediately.
